// File: rtl/grant_ack_arbiter_pkg.sv
// Shared definitions for the GrantAck (TileLink E-channel) arbiter slice.
// Holds the default parameters, the requester-index width helper, the
// E request payload and the output register state encoding.
package grant_ack_arbiter_pkg;

    localparam int unsigned N_REQ_DEF     = 4;
    localparam int unsigned SINK_BITS_DEF = 3;

    // Requester-index width; a single requester still needs one bit.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned SRC_BITS_DEF = idx_bits(N_REQ_DEF);

    // GrantAck payload as carried on the E channel.
    typedef struct packed {
        logic [SINK_BITS_DEF-1:0] sink;
    } e_req_t;

    // Output pipeline register occupancy.
    typedef enum logic {
        E_EMPTY = 1'b0,
        E_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/grant_ack_arbiter_if.sv
// Request/E-channel bundle between the MSHR array, the arbiter and the
// E-channel source queue.
//   io_req_valid/ready/sink : per-requester GrantAck requests
//   io_e_valid/ready/bits_sink/src : downstream E-channel handshake
//   io_dup_err, io_busy : status
// Modport slave is the arbiter side; master is the environment side.
interface grant_ack_arbiter_if
    import grant_ack_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned SINK_BITS = SINK_BITS_DEF
);
    localparam int unsigned SRC_BITS = idx_bits(N_REQ);

    logic [N_REQ-1:0]           io_req_valid;
    logic [N_REQ-1:0]           io_req_ready;
    logic [N_REQ*SINK_BITS-1:0] io_req_sink;
    logic                       io_e_ready;
    logic                       io_e_valid;
    logic [SINK_BITS-1:0]       io_e_bits_sink;
    logic [SRC_BITS-1:0]        io_e_src;
    logic                       io_dup_err;
    logic                       io_busy;

    modport slave (
        input  io_req_valid, io_req_sink, io_e_ready,
        output io_req_ready, io_e_valid, io_e_bits_sink, io_e_src,
               io_dup_err, io_busy
    );

    modport master (
        output io_req_valid, io_req_sink, io_e_ready,
        input  io_req_ready, io_e_valid, io_e_bits_sink, io_e_src,
               io_dup_err, io_busy
    );

endinterface

// File: rtl/grant_ack_arbiter_rr_arbiter_n.sv
// Round-robin priority picker: grants the first set bit of valid found by
// searching upward from ptr, wrapping modulo N. Purely combinational.
//   valid       : request vector
//   ptr         : highest-priority index this cycle (must be < N)
//   grant_c     : one-hot grant (all zero when nothing is valid)
//   grant_idx_c : index of the granted bit (0 when nothing is valid)
//   any_c       : some request is valid
module rr_arbiter_n
    import grant_ack_arbiter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned IDX_BITS = idx_bits(N)
) (
    input  logic [N-1:0]        valid,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [N-1:0]        grant_c,
    output logic [IDX_BITS-1:0] grant_idx_c,
    output logic                any_c
);

    logic [IDX_BITS-1:0] cand;

    // Walk the ring from ptr; the first valid candidate wins.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        cand        = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IDX_BITS'((32'(ptr) + off) % N);
            if (!any_c && valid[cand]) begin
                any_c         = 1'b1;
                grant_idx_c   = cand;
                grant_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grant_ack_arbiter.sv
// GrantAck issue arbiter for the inclusive-cache SourceE stage.
// Round-robin selects one of N_REQ requesters into a one-entry output
// register that drives the E channel at full throughput; a sticky flag
// reports requesters presenting the same sink ID.
//   clock, reset : clock and asynchronous active-high reset
//   io           : request / E-channel bundle (slave side)
module grant_ack_arbiter
    import grant_ack_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned SINK_BITS = SINK_BITS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    grant_ack_arbiter_if.slave   io
);

    localparam int unsigned SRC_BITS = idx_bits(N_REQ);

    out_state_e           state_q, state_d;
    logic [SINK_BITS-1:0] sink_q,  sink_d;
    logic [SRC_BITS-1:0]  src_q,   src_d;
    logic [SRC_BITS-1:0]  ptr_q,   ptr_d;
    logic                 dup_q,   dup_d;

    logic [N_REQ-1:0]     grant_c;
    logic [SRC_BITS-1:0]  grant_idx_c;
    logic                 any_req_c;
    logic                 can_accept_c;
    logic                 accept_c;
    logic                 pair_dup_c;
    logic                 blocked_dup_c;
    logic [SINK_BITS-1:0] granted_sink_c;

    rr_arbiter_n #(
        .N        (N_REQ),
        .IDX_BITS (SRC_BITS)
    ) u_rr (
        .valid       (io.io_req_valid),
        .ptr         (ptr_q),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .any_c       (any_req_c)
    );

    assign can_accept_c   = (state_q == E_EMPTY) || io.io_e_ready;
    assign accept_c       = any_req_c && can_accept_c;
    assign granted_sink_c = io.io_req_sink[32'(grant_idx_c)*SINK_BITS +: SINK_BITS];

    // Any two concurrently valid requesters carrying the same sink ID.
    always_comb begin
        pair_dup_c = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            for (int unsigned j = i + 1; j < N_REQ; j++) begin
                if (io.io_req_valid[i] && io.io_req_valid[j] &&
                    (io.io_req_sink[i*SINK_BITS +: SINK_BITS] ==
                     io.io_req_sink[j*SINK_BITS +: SINK_BITS])) begin
                    pair_dup_c = 1'b1;
                end
            end
        end
    end

    // Accept into a blocked, matching entry; unreachable while accepts are
    // gated by can_accept, kept so the check survives a pipe-rule change.
    assign blocked_dup_c = accept_c && (state_q == E_FULL) && !io.io_e_ready &&
                           (granted_sink_c == sink_q);

    // Next-state: load on accept (also covers depart+accept), drain on departure.
    always_comb begin
        state_d = state_q;
        sink_d  = sink_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        dup_d   = dup_q | pair_dup_c | blocked_dup_c;
        if (accept_c) begin
            state_d = E_FULL;
            sink_d  = granted_sink_c;
            src_d   = grant_idx_c;
            ptr_d   = (grant_idx_c == SRC_BITS'(N_REQ - 1)) ? '0
                                                            : grant_idx_c + SRC_BITS'(1);
        end else if ((state_q == E_FULL) && io.io_e_ready) begin
            state_d = E_EMPTY;
        end
    end

    // State and held-entry registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= E_EMPTY;
            sink_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sink_q  <= sink_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            dup_q   <= dup_d;
        end
    end

    assign io.io_req_ready   = grant_c & {N_REQ{can_accept_c}};
    assign io.io_e_valid     = (state_q == E_FULL);
    assign io.io_e_bits_sink = sink_q;
    assign io.io_e_src       = src_q;
    assign io.io_dup_err     = dup_q;
    assign io.io_busy        = (state_q == E_FULL) || (|io.io_req_valid);

endmodule
